// File: rtl/operand_fetch.sv
// Operand fetch stage: issues register-bank reads for an accepted instruction,
// resolves writeback hazards and holds the resolved operands until execute takes them.
module operand_fetch #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int TAG_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]   rf_dout1,
  input  logic [XLEN-1:0]   rf_dout2,
  input  logic              wb_enable,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [ADDR_W-1:0] out_rd,
  output logic [TAG_W-1:0]  out_tag
);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic [XLEN-1:0]   fwd_data1_q, fwd_data1_d, fwd_data2_q, fwd_data2_d;
  logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic              accept;

  // x0 is hardwired to zero, so a write to it never counts as a hit.
  function automatic logic wb_hit(input logic we, input logic [ADDR_W-1:0] wa,
                                  input logic [ADDR_W-1:0] rs);
    return we && (wa == rs) && (wa != '0);
  endfunction

  function automatic logic [XLEN-1:0] resolve(input logic [ADDR_W-1:0] rs,
                                              input logic hit,
                                              input logic fwd,
                                              input logic [XLEN-1:0] fwd_data,
                                              input logic [XLEN-1:0] dout);
    if (rs == '0)   return '0;
    else if (hit)   return wb_data;
    else if (fwd)   return fwd_data;
    else            return dout;
  endfunction

  assign in_ready  = !reset && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign rf_raddr1 = in_ready ? in_rs1 : rs1_q;
  assign rf_raddr2 = in_ready ? in_rs2 : rs2_q;

  assign out_valid   = (state_q == HOLD);
  assign out_rs1_val = op1_q;
  assign out_rs2_val = op2_q;
  assign out_rd      = rd_q;
  assign out_tag     = tag_q;

  always_comb begin
    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    tag_d       = tag_q;
    fwd1_d      = fwd1_q;
    fwd2_d      = fwd2_q;
    fwd_data1_d = fwd_data1_q;
    fwd_data2_d = fwd_data2_q;
    op1_d       = op1_q;
    op2_d       = op2_q;

    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = HOLD;
      HOLD: begin
        if (accept)         state_d = READ;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The bank returns pre-write data for a write landing in the accept cycle.
    if (accept) begin
      rs1_d  = in_rs1;
      rs2_d  = in_rs2;
      rd_d   = in_rd;
      tag_d  = in_tag;
      fwd1_d = wb_hit(wb_enable, wb_addr, in_rs1);
      fwd2_d = wb_hit(wb_enable, wb_addr, in_rs2);
      if (fwd1_d) fwd_data1_d = wb_data;
      if (fwd2_d) fwd_data2_d = wb_data;
    end

    if (state_q == READ) begin
      op1_d = resolve(rs1_q, wb_hit(wb_enable, wb_addr, rs1_q), fwd1_q, fwd_data1_q, rf_dout1);
      op2_d = resolve(rs2_q, wb_hit(wb_enable, wb_addr, rs2_q), fwd2_q, fwd_data2_q, rf_dout2);
    end else if (state_q == HOLD) begin
      if (wb_hit(wb_enable, wb_addr, rs1_q)) op1_d = wb_data;
      if (wb_hit(wb_enable, wb_addr, rs2_q)) op2_d = wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      tag_q       <= '0;
      fwd1_q      <= 1'b0;
      fwd2_q      <= 1'b0;
      fwd_data1_q <= '0;
      fwd_data2_q <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      tag_q       <= tag_d;
      fwd1_q      <= fwd1_d;
      fwd2_q      <= fwd2_d;
      fwd_data1_q <= fwd_data1_d;
      fwd_data2_q <= fwd_data2_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
    end
  end

endmodule
